// File: rtl/mac_dot_seq.sv
// ----------------------------------------------------------------------------
// mac_dot_seq
//
// Sequencer for a shared combinational MAC (m = a*b + c, DW-bit, wrapping).
// It computes a biased dot product over a streamed vector:
//
//     result = bias + sum(in_a[k] * in_b[k])   (modulo 2^DW)
//
// The MAC itself sits outside this block. The sequencer drives its a/b/c
// inputs and captures its m output as the new accumulator on every accepted
// operand beat.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start, len, bias      command strobe (sampled only in IDLE), vector
//                         length and initial accumulator value
//   busy                  high whenever the sequencer is not in IDLE
//   in_valid, in_ready    operand-pair stream handshake
//   in_a, in_b            operand pair
//   mac_a, mac_b, mac_c   to the MAC a/b/c data inputs
//   mac_m                 from the MAC m data output
//   out_valid, out_ready  result handshake
//   out_data              dot-product result
//   dbg_state             current FSM state, for observation only
//
// Handshake rule for both streams: a transfer happens in a cycle where valid
// and ready are both high at the rising clock edge. in_ready and out_valid
// are decoded from the state register only, so neither depends
// combinationally on in_valid or out_ready.
// ----------------------------------------------------------------------------
module mac_dot_seq #(
    parameter int DW = 8,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          rst,
    // command
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] bias,
    output logic          busy,
    // operand stream
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    // MAC connection
    output logic [DW-1:0] mac_a,
    output logic [DW-1:0] mac_b,
    output logic [DW-1:0] mac_c,
    input  logic [DW-1:0] mac_m,
    // result stream
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    // observation
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] acc_q,   acc_d;
    logic [LW-1:0] cnt_q,   cnt_d;
    logic [LW-1:0] len_q,   len_d;

    logic          in_beat;
    logic          out_beat;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // ------------------------------------------------------------------
    // Handshake decode (state-only ready/valid)
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign in_beat   = in_valid  & in_ready;
    assign out_beat  = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = bias;
                    cnt_d = '0;
                    len_d = len;
                    // A zero-length vector has nothing to stream: the
                    // result is the bias itself.
                    state_d = (len == '0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                // start is deliberately not looked at here, so a command
                // issued mid-vector cannot disturb len_q, acc_q or cnt_q.
                if (in_beat) begin
                    acc_d = mac_m;
                    cnt_d = cnt_q + LW'(1);
                    if (cnt_q == len_q - LW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // acc_q is held, which keeps out_data stable while the
                // downstream side back-pressures.
                if (out_beat) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // MAC drive and result output
    // ------------------------------------------------------------------
    // The MAC is driven in every state; its output only matters on a RUN
    // beat, where it becomes the next accumulator value.
    assign mac_a     = in_a;
    assign mac_b     = in_b;
    assign mac_c     = acc_q;
    assign out_data  = acc_q;
    assign dbg_state = state_q;

endmodule

// File: doc/mac_dot_seq.md
# mac_dot_seq

Sequencer that drives the shared combinational MAC (m = a*b + c, DW-bit, wrapping) to compute a biased dot product over a streamed vector. It accepts a start command with length and bias, pulls operand pairs over a valid/ready stream, and feeds each MAC result back as the next addend. The final sum is presented on a valid/ready output port. The MAC lives beside this block: the sequencer drives its a/b/c inputs and samples its m output.

## Interface
- DW, 8, operand/accumulator width; must match the MAC data width
- LW, 4, width of the length field (max vector length 2^LW-1)

- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  command strobe, sampled only in IDLE
- len  in  LW  vector length, latched on accepted start
- bias  in  DW  initial accumulator value, latched on accepted start
- busy  out  1  high in any state other than IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer accepts operand pair
- in_a, in_b  in  DW each  operand pair
- mac_a, mac_b, mac_c  out  DW each  to MAC a_data/b_data/c_data
- mac_m  in  DW  from MAC m_data
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DW  dot-product result

## Operation
- States: IDLE, RUN, DONE (2-bit encoding; reset state IDLE).
- Registers: acc (DW), cnt (LW), len_r (LW), state.
- IDLE: in_ready=0, out_valid=0, busy=0. On start: acc<=bias, cnt<=0, len_r<=len; if len==0 go to DONE (result = bias), else go to RUN.
- RUN: in_ready=1. On beat (in_valid & in_ready): acc<=mac_m, cnt<=cnt+1; if cnt==len_r-1 go to DONE. No beat: hold everything.
- DONE: out_valid=1, out_data=acc, in_ready=0. On out_valid & out_ready go to IDLE; else hold acc and out_data stable.
- MAC drive (combinational, every state): mac_a=in_a, mac_b=in_b, mac_c=acc. Outside RUN the MAC output is ignored.
- Arithmetic: modulo 2^DW everywhere. Product and sum truncation is done by the MAC; the sequencer adds no width and does no saturation.
- start while busy: ignored, with no effect on len_r, acc or cnt.
- in_valid in IDLE/DONE: not accepted. Upstream must hold the data.
- rst in any state: state=IDLE, acc=0, cnt=0, len_r=0. The current vector is abandoned, with no partial result and no out_valid.

## Timing
- Reset values: busy=0, in_ready=0, out_valid=0, out_data=0, mac_c=0. mac_a/mac_b follow in_a/in_b.
- start in cycle T gives busy=1 and in_ready=1 at T+1 (len>0), or out_valid=1 at T+1 (len==0).
- Throughput: one operand pair per cycle in RUN, with no bubbles required.
- Latency: final beat accepted at cycle T gives out_valid=1 at T+1 with the complete sum.
- Result handshake at cycle T gives IDLE at T+1. A new start is accepted at T+1 at the earliest.
- Minimum command-to-idle: len+2 cycles with no stalls.
- in_ready and out_valid are decoded from state only, with no combinational path from in_valid/out_ready.

## Test plan
- Basic: start len=3 bias=1, pairs (2,3),(3,4),(4,3) back-to-back, out_ready=1. Required: out_valid exactly one cycle after the 3rd beat, out_data=31, IDLE next cycle.
- Stalls: len=4 bias=2, pairs (5,2),(2,4),(1,7),(3,6) with in_valid deasserted 2 cycles between beats. Out_ready low for 3 cycles after out_valid. Required: out_data=45 held stable throughout, acc unchanged on idle cycles.
- Wrap: len=2 bias=0, pairs (16,16),(1,1). Required: out_data=1 (256 wraps to 0). Also len=1 bias=255, pair (1,1): out_data=0.
- Zero length: start len=0 bias=9. Required: out_valid=1 next cycle, out_data=9, no in_ready pulse.
- Illegal start: pulse start with len=1 during RUN of a len=3 job, pairs (1,1),(1,1),(1,1) bias 0. Required: out_data=3 after exactly 3 beats, second start ignored.
- Reset mid-op: assert rst after 2 of 4 beats. Required: next cycle busy=0, in_ready=0, out_valid=0, mac_c=0. A following start len=1 bias=0 with pair (2,3) yields out_data=6.
